// File: rtl/shift_pkg.sv
// Shared constants for the universal shift register: manual mode codes,
// burst directions and the burst controller state encoding.
package shift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic DIR_R = 1'b0;
    localparam logic DIR_L = 1'b1;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst engine: accepts a start request, counts down the clamped shift length
// and issues one shift request per enabled cycle, then pulses done.
module shift_burst_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] len,
    output logic             shift_req,
    output logic             shift_dir,
    output logic             busy,
    output logic             done
);

    logic             state;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;
    logic             done_q;
    logic [CNT_W-1:0] len_clamped;

    // Longer requests than the register width would only shift in more
    // serial bits over data that is already fully replaced.
    assign len_clamped = (len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            dir_q  <= DIR_R;
            done_q <= 1'b0;
        end else if (enable) begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dir_q <= dir;
                        cnt   <= len_clamped;
                        state <= ST_RUN;
                    end
                end
                default: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
            endcase
        end else begin
            done_q <= 1'b0;
        end
    end

    assign busy      = (state == ST_RUN);
    assign done      = done_q;
    assign shift_req = enable && busy && (cnt != '0);
    assign shift_dir = dir_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register datapath: manual hold/shift/load in idle, and
// burst shifts driven by shift_burst_ctrl while busy.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] len,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic             busy,
    output logic             done
);

    logic shift_req;
    logic shift_dir;
    logic manual_en;

    shift_burst_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .start     (start),
        .dir       (dir),
        .len       (len),
        .shift_req (shift_req),
        .shift_dir (shift_dir),
        .busy      (busy),
        .done      (done)
    );

    // The accepting edge of a burst holds q, so start also blocks manual ops.
    assign manual_en = enable && !busy && !start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (shift_req) begin
            if (shift_dir == DIR_L) begin
                q <= {q[WIDTH-2:0], ser_in_lsb};
            end else begin
                q <= {ser_in_msb, q[WIDTH-1:1]};
            end
        end else if (manual_en) begin
            case (mode)
                MODE_SHR:  q <= {ser_in_msb, q[WIDTH-1:1]};
                MODE_SHL:  q <= {q[WIDTH-2:0], ser_in_lsb};
                MODE_LOAD: q <= d;
                default:   q <= q;
            endcase
        end
    end

    assign ser_out_msb = q[WIDTH-1];
    assign ser_out_lsb = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8) with hand-computed expectations.
module tb_univ_shift_reg;
    import shift_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic [1:0]       mode;
    logic [WIDTH-1:0] d;
    logic             ser_in_msb;
    logic             ser_in_lsb;
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] len;
    logic [WIDTH-1:0] q;
    logic             ser_out_msb;
    logic             ser_out_lsb;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;
    int busyCycles;

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .mode        (mode),
        .d           (d),
        .ser_in_msb  (ser_in_msb),
        .ser_in_lsb  (ser_in_lsb),
        .start       (start),
        .dir         (dir),
        .len         (len),
        .q           (q),
        .ser_out_msb (ser_out_msb),
        .ser_out_lsb (ser_out_lsb),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'($urandom);
        mode       = 2'($urandom);
        d          = 8'($urandom);
        ser_in_msb = 1'($urandom);
        ser_in_lsb = 1'($urandom);
        start      = 1'($urandom);
        dir        = 1'($urandom);
        len        = 4'($urandom);
        #22;
        checkOutput("reset_q", 32'(q), 32'h00);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_done", 32'(done), 32'h0);

        enable = 1'b1; mode = MODE_HOLD; d = '0; start = 1'b0;
        ser_in_msb = 1'b0; ser_in_lsb = 1'b0; dir = DIR_R; len = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // manual load and shift right
        mode = MODE_LOAD; d = 8'hA5;
        applyStimulus();
        checkOutput("load_a5", 32'(q), 32'hA5);
        mode = MODE_SHR; ser_in_msb = 1'b1;
        applyStimulus();
        checkOutput("shr_q", 32'(q), 32'hD2);
        checkOutput("shr_ser_out_lsb", 32'(ser_out_lsb), 32'h0);
        checkOutput("shr_ser_out_msb", 32'(ser_out_msb), 32'h1);
        mode = MODE_SHL; ser_in_lsb = 1'b1;
        applyStimulus();
        checkOutput("shl_q", 32'(q), 32'hA5);

        // enable gating
        mode = MODE_LOAD; d = 8'h3C;
        applyStimulus();
        enable = 1'b0; d = 8'hFF;
        for (int i = 0; i < 5; i++) applyStimulus();
        checkOutput("gated_q", 32'(q), 32'h3C);
        enable = 1'b1;

        // burst left, len 3, manual load requested throughout
        mode = MODE_LOAD; d = 8'h01;
        applyStimulus();
        d = 8'hFF; start = 1'b1; dir = DIR_L; len = 4'd3; ser_in_lsb = 1'b0;
        applyStimulus();
        start = 1'b0; dir = DIR_R; len = 4'd0;
        checkOutput("bl_accept_busy", 32'(busy), 32'h1);
        checkOutput("bl_accept_q", 32'(q), 32'h01);
        applyStimulus();
        checkOutput("bl_shift1_q", 32'(q), 32'h02);
        applyStimulus();
        checkOutput("bl_shift2_q", 32'(q), 32'h04);
        applyStimulus();
        checkOutput("bl_shift3_q", 32'(q), 32'h08);
        checkOutput("bl_shift3_busy", 32'(busy), 32'h1);
        checkOutput("bl_shift3_done", 32'(done), 32'h0);
        mode = MODE_HOLD;
        applyStimulus();
        checkOutput("bl_end_busy", 32'(busy), 32'h0);
        checkOutput("bl_end_done", 32'(done), 32'h1);
        checkOutput("bl_end_q", 32'(q), 32'h08);
        applyStimulus();
        checkOutput("bl_after_done", 32'(done), 32'h0);

        // clamped right burst with a two-cycle stall
        mode = MODE_LOAD; d = 8'hFF;
        applyStimulus();
        mode = MODE_HOLD; start = 1'b1; dir = DIR_R; len = 4'd12; ser_in_msb = 1'b0;
        applyStimulus();
        start = 1'b0; len = 4'd0;
        busyCycles = busy ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            if (busy) busyCycles++;
        end
        checkOutput("clamp_pre_stall_q", 32'(q), 32'h1F);
        enable = 1'b0;
        applyStimulus();
        if (busy) busyCycles++;
        checkOutput("clamp_stall_done", 32'(done), 32'h0);
        applyStimulus();
        if (busy) busyCycles++;
        checkOutput("clamp_stall_q", 32'(q), 32'h1F);
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            if (busy) busyCycles++;
            checkOutput("clamp_no_early_done", 32'(done), 32'h0);
        end
        checkOutput("clamp_final_q", 32'(q), 32'h00);
        applyStimulus();
        if (busy) busyCycles++;
        checkOutput("clamp_done", 32'(done), 32'h1);
        checkOutput("clamp_busy_cycles", 32'(busyCycles), 32'd11);

        // zero length, back-to-back start, reset mid-burst
        mode = MODE_LOAD; d = 8'h5A;
        applyStimulus();
        mode = MODE_HOLD; start = 1'b1; dir = DIR_R; len = 4'd0;
        applyStimulus();
        start = 1'b0;
        checkOutput("zero_accept_busy", 32'(busy), 32'h1);
        applyStimulus();
        checkOutput("zero_done", 32'(done), 32'h1);
        checkOutput("zero_q", 32'(q), 32'h5A);
        start = 1'b1; dir = DIR_L; len = 4'd4; ser_in_lsb = 1'b1;
        applyStimulus();
        start = 1'b0;
        checkOutput("rearm_busy", 32'(busy), 32'h1);
        checkOutput("rearm_done", 32'(done), 32'h0);
        applyStimulus();
        checkOutput("rearm_shift_q", 32'(q), 32'hB5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_q", 32'(q), 32'h00);
        checkOutput("async_rst_busy", 32'(busy), 32'h0);
        checkOutput("async_rst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus();
        checkOutput("post_rst_busy", 32'(busy), 32'h0);
        checkOutput("post_rst_q", 32'(q), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
